// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared definitions for the SPI flash read bridge.
//   state_e     controller states
//   CMD_READ    flash READ DATA opcode
//   CMD_WAKE    flash release-from-power-down opcode
//   WAKE_BITS   length of the wake frame in bits
//   XFER_BITS   length of the command/address and data phases in bits
//   byte_swap32 reorders a MSB-first received stream into a little-endian word
package spi_flash_pkg;

  typedef enum logic [2:0] {
    StWake     = 3'd0,
    StWakeWait = 3'd1,
    StIdle     = 3'd2,
    StCmd      = 3'd3,
    StData     = 3'd4,
    StDone     = 3'd5,
    StDesel    = 3'd6
  } state_e;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WAKE  = 8'hAB;
  localparam logic [5:0] WAKE_BITS = 6'd8;
  localparam logic [5:0] XFER_BITS = 6'd32;

  // The first byte off the wire lands in [31:24] of the shift register but
  // belongs in [7:0] of the bus word.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_shifter.sv
// spi_shifter: SPI mode-0 bit engine running SCK at clk/2.
//   clk, reset  system clock, synchronous active-high reset
//   load        start a frame: capture tx_data and nbits, SCK low
//   tx_data     frame to send, MSB first from bit 31
//   nbits       number of bits in the frame (1..32)
//   miso        serial input, sampled at the end of each SCK-high cycle
//   sck         SPI clock
//   mosi        serial output, changes only while SCK is low
//   rx_data     received bits, first bit in the highest used position
//   done        high on the last SCK-high cycle of a frame
module spi_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] tx_data,
  input  logic [5:0]  nbits,
  input  logic        miso,
  output logic        sck,
  output logic        mosi,
  output logic [31:0] rx_data,
  output logic        done
);

  logic        active_q, active_d;
  logic        sck_q, sck_d;
  logic [31:0] shreg_q, shreg_d;
  logic [31:0] rx_q, rx_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  nbits_q, nbits_d;
  logic        last_bit;

  assign last_bit = (cnt_q == nbits_q - 6'd1);
  assign done     = active_q & sck_q & last_bit;

  always_comb begin
    active_d = active_q;
    sck_d    = sck_q;
    shreg_d  = shreg_q;
    rx_d     = rx_q;
    cnt_d    = cnt_q;
    nbits_d  = nbits_q;
    if (load) begin
      active_d = 1'b1;
      sck_d    = 1'b0;
      shreg_d  = tx_data;
      rx_d     = '0;
      cnt_d    = '0;
      nbits_d  = nbits;
    end else if (active_q) begin
      if (!sck_q) begin
        sck_d = 1'b1;
      end else begin
        // Falling SCK: take the bit sampled during the high phase and present
        // the next output bit for the coming low phase.
        sck_d = 1'b0;
        rx_d  = {rx_q[30:0], miso};
        if (last_bit) begin
          active_d = 1'b0;
          shreg_d  = '0;
        end else begin
          shreg_d = {shreg_q[30:0], 1'b0};
          cnt_d   = cnt_q + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      shreg_q  <= '0;
      rx_q     <= '0;
      cnt_q    <= '0;
      nbits_q  <= '0;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      shreg_q  <= shreg_d;
      rx_q     <= rx_d;
      cnt_q    <= cnt_d;
      nbits_q  <= nbits_d;
    end
  end

  assign sck     = sck_q;
  assign mosi    = shreg_q[31];
  assign rx_data = rx_q;

endmodule

// File: rtl/spi_flash.sv
// spi_flash: read-only memory-mapped bridge to a SPI NOR flash.
// After reset it wakes the flash (0xAB), waits WAKE_CYCLES, then serves
// 32-bit reads with READ (0x03) + 24-bit address and acknowledges writes
// without touching the flash.
//   clk, reset       system clock, synchronous active-high reset
//   address_in       bus byte address (bits 23:2 used)
//   sel_in           block selected
//   read_in          read strobe
//   write_mask_in    byte write enables
//   read_value_out   read data, zero unless completing a read with sel_in=1
//   ready_out        one-cycle completion pulse
//   flash_clk        SCK
//   flash_csn        chip select, active low
//   flash_io0_out    MOSI
//   flash_io0_en     MOSI output enable
//   flash_io1_en     MISO output enable, always 0
//   flash_io1_in     MISO
module spi_flash import spi_flash_pkg::*; #(
  parameter logic [23:0] FLASH_OFFSET = 24'h000000,
  parameter logic [15:0] WAKE_CYCLES  = 16'd48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  input  logic [3:0]  write_mask_in,
  output logic [31:0] read_value_out,
  output logic        ready_out,
  output logic        flash_clk,
  output logic        flash_csn,
  output logic        flash_io0_out,
  output logic        flash_io0_en,
  output logic        flash_io1_en,
  input  logic        flash_io1_in
);

  state_e      state_q, state_d;
  logic        csn_q, csn_d;
  logic [15:0] wait_q, wait_d;
  logic        wr_ack_q, wr_ack_d;

  logic        sh_load;
  logic [31:0] sh_tx;
  logic [5:0]  sh_nbits;
  logic        sh_done;
  logic        sh_sck;
  logic        sh_mosi;
  logic [31:0] sh_rx;

  logic [23:0] flash_addr;
  logic [16:0] wait_next;
  logic        unused_addr;

  // Word-aligned address plus offset; the 24-bit sum drops any carry.
  assign flash_addr  = {address_in[23:2], 2'b00} + FLASH_OFFSET;
  assign wait_next   = {1'b0, wait_q} + 17'd1;
  assign unused_addr = ^{address_in[31:24], address_in[1:0]};

  always_comb begin
    state_d  = state_q;
    csn_d    = csn_q;
    wait_d   = wait_q;
    wr_ack_d = 1'b0;
    sh_load  = 1'b0;
    sh_tx    = '0;
    sh_nbits = XFER_BITS;
    unique case (state_q)
      StWake: begin
        // csn is still high on the first cycle after reset: start the frame.
        if (csn_q) begin
          sh_load  = 1'b1;
          sh_tx    = {CMD_WAKE, 24'h000000};
          sh_nbits = WAKE_BITS;
          csn_d    = 1'b0;
        end else if (sh_done) begin
          csn_d   = 1'b1;
          wait_d  = '0;
          state_d = StWakeWait;
        end
      end
      StWakeWait: begin
        if (wait_next >= {1'b0, WAKE_CYCLES}) begin
          state_d = StIdle;
        end else begin
          wait_d = wait_next[15:0];
        end
      end
      StIdle: begin
        if (sel_in && read_in) begin
          sh_load  = 1'b1;
          sh_tx    = {CMD_READ, flash_addr};
          sh_nbits = XFER_BITS;
          csn_d    = 1'b0;
          state_d  = StCmd;
        end else if (sel_in && (write_mask_in != 4'h0) && !wr_ack_q) begin
          // The held write is already acknowledged while wr_ack_q is high.
          wr_ack_d = 1'b1;
        end
      end
      StCmd: begin
        if (sh_done) begin
          sh_load  = 1'b1;
          sh_tx    = '0;
          sh_nbits = XFER_BITS;
          state_d  = StData;
        end
      end
      StData: begin
        if (sh_done) begin
          csn_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        wait_d  = '0;
        state_d = StDesel;
      end
      StDesel: begin
        if (wait_q == 16'd1) begin
          state_d = StIdle;
        end else begin
          wait_d = wait_next[15:0];
        end
      end
      default: begin
        csn_d   = 1'b1;
        state_d = StWake;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StWake;
      csn_q    <= 1'b1;
      wait_q   <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      csn_q    <= csn_d;
      wait_q   <= wait_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  spi_shifter u_shifter (
    .clk     (clk),
    .reset   (reset),
    .load    (sh_load),
    .tx_data (sh_tx),
    .nbits   (sh_nbits),
    .miso    (flash_io1_in),
    .sck     (sh_sck),
    .mosi    (sh_mosi),
    .rx_data (sh_rx),
    .done    (sh_done)
  );

  assign ready_out      = (state_q == StDone) | wr_ack_q;
  assign read_value_out = ((state_q == StDone) && sel_in) ? byte_swap32(sh_rx) : 32'h0;
  assign flash_clk      = sh_sck;
  assign flash_csn      = csn_q;
  assign flash_io0_out  = sh_mosi;
  assign flash_io0_en   = ~csn_q;
  assign flash_io1_en   = 1'b0;

endmodule
